// File: rtl/muldiv_scheduler.sv
// muldiv_scheduler: multi-cycle mult/div sequencer owning HI/LO, with ID-stage stall request.
// Optional MD_STALL_CNT_EN adds a stall_cnt output counting md_stall cycles.
module muldiv_scheduler #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_uses_md,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
`ifdef MD_STALL_CNT_EN
  , output logic [31:0] stall_cnt
`endif
);
  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t r_state, w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [31:0] r_hi, r_lo, r_phi, r_plo;
  logic r_pwr;
  logic w_go, w_last, w_sa, w_sb;
  logic [63:0] w_smul, w_umul, w_res;
  logic [31:0] w_ua, w_ub, w_uq, w_ur, w_q, w_r;
  assign busy     = (r_state == RUN);
  assign md_stall = d_uses_md & (busy | start);
  assign hi       = r_hi;
  assign lo       = r_lo;
  assign w_go     = start & (r_state == IDLE) & ~op[2];
  assign w_last   = (r_cnt == CW'(1));
  assign w_smul   = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
  assign w_umul   = {32'b0, rs_val} * {32'b0, rt_val};
  // Signed divide via magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
  assign w_sa     = ~op[0] & rs_val[31];
  assign w_sb     = ~op[0] & rt_val[31];
  assign w_ua     = w_sa ? 32'(-rs_val) : rs_val;
  assign w_ub     = w_sb ? 32'(-rt_val) : rt_val;
  assign w_uq     = (w_ub == 32'd0) ? 32'd0 : w_ua / w_ub;
  assign w_ur     = (w_ub == 32'd0) ? 32'd0 : w_ua % w_ub;
  assign w_q      = (w_sa ^ w_sb) ? 32'(-w_uq) : w_uq;
  assign w_r      = w_sa ? 32'(-w_ur) : w_ur;
  assign w_res    = op[1] ? {w_r, w_q} : (op[0] ? w_umul : w_smul);
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == IDLE) w_state_nxt = w_go ? RUN : IDLE;
    else                 w_state_nxt = w_last ? IDLE : RUN;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_phi   <= '0;
      r_plo   <= '0;
      r_pwr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_go) begin
        r_cnt <= op[1] ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
        r_phi <= w_res[63:32];
        r_plo <= w_res[31:0];
        r_pwr <= ~op[1] | (rt_val != 32'd0);
      end else if (r_state == RUN) begin
        r_cnt <= r_cnt - CW'(1);
        if (w_last && r_pwr) begin
          r_hi <= r_phi;
          r_lo <= r_plo;
        end
      end else if (start && op == 3'd4) begin
        r_hi <= rs_val;
      end else if (start && op == 3'd5) begin
        r_lo <= rs_val;
      end
    end
  end
`ifdef MD_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)         stall_cnt <= '0;
    else if (md_stall) stall_cnt <= stall_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_muldiv_scheduler.sv
// tb_muldiv_scheduler: randomized self-checking bench for muldiv_scheduler against an arithmetic HI/LO model.
module tb_muldiv_scheduler;
  localparam int MUL_N = 5;
  localparam int DIV_N = 10;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [2:0] op = 3'd0;
  logic [31:0] rs_val = '0, rt_val = '0;
  logic d_uses_md = 1'b0;
  logic busy, md_stall;
  logic [31:0] hi, lo;
`ifdef MD_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif
  int errors = 0, checks = 0;
  logic [31:0] mhi = '0, mlo = '0;

  muldiv_scheduler #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .d_uses_md(d_uses_md), .busy(busy), .md_stall(md_stall), .hi(hi), .lo(lo)
`ifdef MD_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic int exp_busy(input logic [2:0] o);
    return (o < 3'd2) ? MUL_N : (o < 3'd4) ? DIV_N : 0;
  endfunction

  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'd0: begin p = 64'(sa * sb); {mhi, mlo} = p; end
      3'd1: begin p = {32'b0, a} * {32'b0, b}; {mhi, mlo} = p; end
      3'd2: if (b != 0) begin mlo = 32'(sa / sb); mhi = 32'(sa % sb); end
      3'd3: if (b != 0) begin mlo = a / b; mhi = a % b; end
      3'd4: mhi = a;
      3'd5: mlo = a;
      default: ;
    endcase
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int nb, output logic [31:0] h, output logic [31:0] l);
    @(negedge clk);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(negedge clk);
    start = 1'b0; op = 3'($urandom); rs_val = $urandom; rt_val = $urandom;
    nb = 0;
    while (busy === 1'b1 && nb < 40) begin
      nb++;
      @(negedge clk);
    end
    h = hi;
    l = lo;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    mhi = '0; mlo = '0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (md_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", md_stall); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi got=%h exp=0", hi); end
    checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo got=%h exp=0", lo); end
`ifdef MD_STALL_CNT_EN
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); end
`endif
  endtask

  task automatic test_muldiv;
    logic [2:0] to[8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd2, 3'd2, 3'd1, 3'd0};
    logic [31:0] ta[8] = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFF9, 32'd7, 32'h80000000, 32'd100, 32'hFFFFFFFF, 32'h80000000};
    logic [31:0] tb[8] = '{32'd3, 32'd3, 32'd2, 32'd0, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF, 32'h80000000};
    int nb;
    logic [31:0] h, l;
    for (int i = 0; i < 8; i++) begin
      model(to[i], ta[i], tb[i]);
      run_op(to[i], ta[i], tb[i], nb, h, l);
      checks++; if (nb !== exp_busy(to[i])) begin errors++; $display("FAIL dir%0d_busy got=%0d exp=%0d", i, nb, exp_busy(to[i])); end
      checks++; if (h !== mhi) begin errors++; $display("FAIL dir%0d_hi got=%h exp=%h", i, h, mhi); end
      checks++; if (l !== mlo) begin errors++; $display("FAIL dir%0d_lo got=%h exp=%h", i, l, mlo); end
    end
  endtask

  task automatic test_mt;
    logic [2:0] to[4] = '{3'd4, 3'd5, 3'd6, 3'd7};
    logic [31:0] ta[4] = '{32'h12345678, 32'hCAFEF00D, 32'hDEADBEEF, 32'h0BADF00D};
    int nb;
    logic [31:0] h, l;
    for (int i = 0; i < 4; i++) begin
      model(to[i], ta[i], 32'd0);
      run_op(to[i], ta[i], 32'd0, nb, h, l);
      checks++; if (nb !== 0) begin errors++; $display("FAIL mt%0d_busy got=%0d exp=0", i, nb); end
      checks++; if (h !== mhi) begin errors++; $display("FAIL mt%0d_hi got=%h exp=%h", i, h, mhi); end
      checks++; if (l !== mlo) begin errors++; $display("FAIL mt%0d_lo got=%h exp=%h", i, l, mlo); end
    end
  endtask

  task automatic test_stall;
    int ns;
    for (int pass = 0; pass < 2; pass++) begin
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      mhi = '0; mlo = '0;
      d_uses_md = (pass == 0);
      @(negedge clk);
      start = 1'b1; op = 3'd0; rs_val = 32'hFFFFFFFE; rt_val = 32'd3;
      model(3'd0, 32'hFFFFFFFE, 32'd3);
      #1 ns = int'(md_stall);
      @(posedge clk);
      #1 start = 1'b0;
      for (int i = 0; i < MUL_N; i++) begin
        @(negedge clk);
        ns += int'(md_stall);
      end
      @(negedge clk);
      checks++; if (ns !== (pass == 0 ? MUL_N + 1 : 0)) begin errors++; $display("FAIL stall%0d_cycles got=%0d exp=%0d", pass, ns, pass == 0 ? MUL_N + 1 : 0); end
      checks++; if (md_stall !== 1'b0) begin errors++; $display("FAIL stall%0d_after got=%b exp=0", pass, md_stall); end
      checks++; if (hi !== mhi || lo !== mlo) begin errors++; $display("FAIL stall%0d_result got=%h_%h exp=%h_%h", pass, hi, lo, mhi, mlo); end
`ifdef MD_STALL_CNT_EN
      checks++; if (stall_cnt !== 32'(pass == 0 ? MUL_N + 1 : 0)) begin errors++; $display("FAIL stall%0d_cnt got=%0d exp=%0d", pass, stall_cnt, pass == 0 ? MUL_N + 1 : 0); end
`endif
      d_uses_md = 1'b0;
    end
  endtask

  task automatic test_ignore;
    int nb;
    logic [31:0] a, b;
    a = $urandom; b = $urandom | 32'd1;
    model(3'd2, a, b);
    @(negedge clk);
    start = 1'b1; op = 3'd2; rs_val = a; rt_val = b;
    @(negedge clk);
    start = 1'b0;
    nb = 0;
    while (busy === 1'b1 && nb < 40) begin
      nb++;
      if (nb == 3) begin start = 1'b1; op = 3'd0; rs_val = $urandom; rt_val = $urandom; end
      else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    checks++; if (nb !== DIV_N) begin errors++; $display("FAIL ignore_busy got=%0d exp=%0d", nb, DIV_N); end
    checks++; if (hi !== mhi) begin errors++; $display("FAIL ignore_hi got=%h exp=%h", hi, mhi); end
    checks++; if (lo !== mlo) begin errors++; $display("FAIL ignore_lo got=%h exp=%h", lo, mlo); end
  endtask

  task automatic test_reset_mid;
    int nb;
    @(negedge clk);
    start = 1'b1; op = 3'd3; rs_val = 32'd1000; rt_val = 32'd7;
    @(negedge clk);
    start = 1'b0;
    nb = 1;
    while (busy === 1'b1 && nb < 3) begin nb++; @(negedge clk); end
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    mhi = '0; mlo = '0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL rstmid_hilo got=%h_%h exp=0_0", hi, lo); end
    repeat (DIV_N + 4) @(negedge clk);
    checks++; if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_late got=%h_%h busy=%b exp=0_0 busy=0", hi, lo, busy); end
  endtask

  task automatic test_random;
    int nb;
    logic [2:0] o;
    logic [31:0] a, b, h, l;
    for (int i = 0; i < 24; i++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31);
      model(o, a, b);
      run_op(o, a, b, nb, h, l);
      checks++; if (nb !== exp_busy(o) || h !== mhi || l !== mlo) begin
        errors++; $display("FAIL rnd%0d op=%0d a=%h b=%h got busy=%0d %h_%h exp busy=%0d %h_%h", i, o, a, b, nb, h, l, exp_busy(o), mhi, mlo);
      end
    end
  endtask

  initial begin
    test_reset;
    test_muldiv;
    test_mt;
    test_stall;
    test_ignore;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/muldiv_scheduler.md
Name: muldiv_scheduler

Overview:
- Multi-cycle multiply/divide sequencer and HI/LO owner for the 5-stage MIPS pipeline.
- Accepts one mult/div/mthi/mtlo command per issue from the EX stage and models the fixed execution latency with a countdown.
- Publishes HI/LO for mfhi/mflo.
- Drives a stall request to the ID/EX boundary so that HI/LO-dependent instructions are held in D while the unit is occupied.

Parameters:
- MUL_CYCLES, 5, busy cycles for MULT/MULTU (must be >= 1)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (must be >= 1)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  EX-stage instruction is a HI/LO-writing op this cycle
- op  in  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO, others=no-op
- rs_val  in  32  forwarded rs operand
- rt_val  in  32  forwarded rt operand
- d_uses_md  in  1  instruction in D is mult/div/mthi/mtlo/mfhi/mflo
- busy  out  1  operation in progress
- md_stall  out  1  stall request to the ID stage
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Reset (takes priority over everything, including mid-operation):
  - state=IDLE, counter=0, busy=0, hi=0, lo=0.
  - Any pending result is discarded.
- States: IDLE, RUN.
- IDLE, start=1, op in {MULT, MULTU, DIV, DIVU}:
  - Compute the result combinationally from rs_val/rt_val and latch it into pending_hi/pending_lo.
  - Load counter with MUL_CYCLES or DIV_CYCLES.
  - Go to RUN. busy=1 from the next edge.
- RUN:
  - Decrement counter each cycle.
  - On the edge where counter==1: hi<=pending_hi, lo<=pending_lo, busy<=0, state<=IDLE.
  - busy is therefore high for exactly N cycles. New HI/LO values become visible in the same cycle busy first reads 0.
- IDLE, start=1, op=MTHI: hi<=rs_val at the next edge. No busy. op=MTLO is the same with lo.
- start=1 while busy=1: ignored, with no state change. Upstream stalling guarantees this does not happen; the bench checks that it is ignored.
- start=1 with an undefined op: no effect.
- md_stall = d_uses_md & (busy | start). This is combinational and asserts in the issue cycle itself.
- Arithmetic:
  - MULT: {hi,lo} = signed 64-bit product.
  - MULTU: {hi,lo} = unsigned 64-bit product.
  - DIV: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - Divisor==0: the operation still takes DIV_CYCLES, but hi/lo keep their prior values at completion.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Operands are sampled only in the start cycle. Later changes on rs_val/rt_val have no effect.

Optional Feature:
- Macro: MD_STALL_CNT_EN
- Defined:
  - Adds output stall_cnt[31:0], which counts cycles with md_stall=1.
  - Reset to 0 by reset. Wraps modulo 2^32.
- Undefined: the port and counter do not exist. All other behaviour is identical.

Test Plan:
- MULT rs=0xFFFFFFFE (-2), rt=3 → busy high exactly 5 cycles; at its fall hi=0xFFFFFFFF, lo=0xFFFFFFFA; MULTU with the same operands → hi=0x00000002, lo=0xFFFFFFFA.
- DIV rs=0xFFFFFFF9 (-7), rt=2 → after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/0 → hi/lo unchanged after 10 cycles.
- Stall timing: start=1 (MULT) with d_uses_md=1 → md_stall=1 in the issue cycle and the 5 busy cycles, 0 on the cycle after; with d_uses_md=0, md_stall stays 0 throughout.
- MTHI rs=0x12345678 → hi=0x12345678 after one edge with busy=0 throughout; start=1 with a MULT during a running DIV → ignored, and DIV result delivered unchanged.
- Reset asserted at busy cycle 3 of a DIV → next cycle busy=0, hi=lo=0, and no later writeback occurs.
- With MD_STALL_CNT_EN: the MULT stall scenario above → stall_cnt=6; reset → stall_cnt=0.
